pool_sequencer: RTL and testbench
=================================

// Module: pool_sequencer
// PURPOSE
//  Sequences the lockstep hashing pool inside top: loads a job's nonce start, steps
//  all POOL_SIZE cores through HASH_CYCLES rounds per attempt and strides the nonce base.
//  Resolves the success flags of simultaneous winners by priority, latches the winner
//  and raises ready. Sits between the SPI job-load path and the core array.
// PARAMETERS
//  POOL_SIZE       2   number of hashing cores; core i tries nonce_base+i
//  POOL_SIZE_LOG2  1   width of the core index (>=1)
//  HASH_CYCLES     64  clock cycles per hash attempt (round counter period)
//  ROUND_W         6   width of round counter; 2**ROUND_W >= HASH_CYCLES
//  LED_DIV         22  heartbeat divider exponent (SEQ_STATUS_LED_EN only)
// PORTS
//  clk_in            in   1              system clock (PLL global clock)
//  reset_n_in        in   1              synchronous active-low reset
//  job_load_in       in   1              1-cycle pulse: new job loaded, start hashing
//  nonce_start_in    in   32             first nonce base, sampled on job_load_in
//  halt_in           in   1              level: abandon work, return to IDLE
//  core_success_in   in   POOL_SIZE      per-core hit flag; valid only while strobe high
//  pool_clear_out    out  1              1-cycle sync clear of core state at job start
//  pool_round_out    out  ROUND_W        current round index broadcast to all cores
//  pool_strobe_out   out  1              high in the last round of each attempt
//  nonce_base_out    out  32             nonce of core 0 for current attempt
//  winner_idx_out    out  POOL_SIZE_LOG2 index of winning core (valid with ready_out)
//  winner_nonce_out  out  32             nonce_base+winner_idx (valid with ready_out)
//  ready_out         out  1              result found; drives ready open-drain in top
//  exhausted_out     out  1              nonce space finished with no hit
//  busy_out          out  1              high in PRIME and RUN
//  status_led_n_out  out  1              active-low status LED
// BEHAVIOUR
//  - Reset (reset_n_in=0 at an edge): state IDLE; every output 0, except status_led_n_out=1.
//  - States: IDLE, PRIME, RUN, FOUND, EXHAUSTED (encodings in shared header).
//  - Priority per cycle: reset > halt_in > job_load_in > normal transition.
//  - halt_in=1: next state IDLE; round, strobe, clear, busy, ready and exhausted all 0;
//    winner regs keep their values.
//  - job_load_in (any state except under halt): next state PRIME; nonce_base<=nonce_start_in;
//    ready/exhausted cleared. A reload in RUN abandons the attempt in flight.
//  - PRIME: one cycle; pool_clear_out=1 and round=0; then RUN.
//  - RUN: round counts 0..HASH_CYCLES-1. pool_strobe_out=1 iff round==HASH_CYCLES-1.
//    On the strobe cycle core_success_in is sampled:
//      * any bit set: lowest set index wins; winner_idx<=idx;
//        winner_nonce<=nonce_base+idx (mod 2^32); next FOUND.
//      * none set, nonce_base+POOL_SIZE overflows 33-bit sum: next EXHAUSTED.
//      * otherwise: nonce_base+=POOL_SIZE; round<=0; stay RUN (no idle cycle).
//  - core_success_in is ignored outside the strobe cycle.
//  - FOUND: ready_out=1. EXHAUSTED: exhausted_out=1. Both hold until job_load_in or
//    halt_in; round frozen at 0, no strobes.
//  - Latency: job_load pulse at cycle t -> clear at t+1 -> round 0 at t+2 -> first
//    strobe at t+1+HASH_CYCLES -> ready at t+2+HASH_CYCLES.
//  - busy_out = (state==PRIME)|(state==RUN). All outputs are registered.
// CONFIGURATION
//  SEQ_STATUS_LED_EN defined:
//    - IDLE: LED off.
//    - RUN: LED toggles every 2**LED_DIV cycles (free-running counter, reset to 0).
//    - FOUND: solid on. EXHAUSTED: off.
//    - Output is active-low.
//  Not defined: status_led_n_out is tied to 1; no divider counter is built.
// STRUCTURE
//  - Shared header pool_seq_defs.vh:
//    * state encodings (3-bit localparams)
//    * NONCE_W=32
//  - Sub-module pool_priority_enc (POOL_SIZE, POOL_SIZE_LOG2):
//    * combinational lowest-index encoder
//    * outputs idx and any
//  - All sequencing lives in pool_sequencer.
// TESTING
//  1 reset mid-RUN -> all outputs 0 on the next edge and status_led_n_out=1; state IDLE.
//  2 job_load start=0x00001000, success never set -> strobe every 64 cycles;
//    nonce_base 0x1000, 0x1002, 0x1004...
//  3 on the 3rd strobe core_success_in=2'b11 -> winner_idx=0, winner_nonce=0x1004,
//    ready_out=1 and held.
//  4 start=0xFFFFFFFE, POOL_SIZE=2, no hit -> exhausted_out=1 after the first strobe;
//    ready_out stays 0.
//  5 halt_in and job_load_in in the same cycle -> IDLE, no pool_clear_out pulse;
//    job_load_in during FOUND -> PRIME, ready_out drops.
//  6 SEQ_STATUS_LED_EN with LED_DIV=3 -> LED toggles every 8 cycles in RUN, low in FOUND;
//    without the macro -> constant 1.

Source files
------------

// File: rtl/pool_sequencer_pkg.sv
// Shared definitions for the hashing-pool sequencer: state encodings and nonce width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pool_sequencer_pkg;

   localparam int NONCE_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRIME     = 3'd1,
      ST_RUN       = 3'd2,
      ST_FOUND     = 3'd3,
      ST_EXHAUSTED = 3'd4
   } seq_state_t;

endpackage

// File: rtl/pool_sequencer_priority_enc.sv
// Lowest-index priority encoder over the per-core success flags.
// Latency: combinational.
// Backpressure: none.
// Ports: req (one flag per core) -> idx (lowest set index, 0 if none), any (some flag set).
module pool_priority_enc #(
   parameter int POOL_SIZE      = 2,
   parameter int POOL_SIZE_LOG2 = 1
) (
   input  logic [POOL_SIZE-1:0]      req,
   output logic [POOL_SIZE_LOG2-1:0] idx,
   output logic                      any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = POOL_SIZE - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = POOL_SIZE_LOG2'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pool_sequencer.sv
// Sequences the lockstep hashing pool: job load, per-attempt round stepping, nonce striding, winner latch.
// Latency: job_load_in at t -> pool_clear_out t+1 -> round 0 t+2 -> strobe t+1+HASH_CYCLES -> ready t+2+HASH_CYCLES.
// Backpressure: none; halt_in abandons work immediately, job_load_in restarts from any state.
// Ports: clk_in/reset_n_in (sync active-low); job_load_in+nonce_start_in start a job; halt_in forces IDLE;
//        core_success_in sampled only on the strobe cycle; pool_* drive the core array; winner_*/ready_out,
//        exhausted_out, busy_out report status; status_led_n_out is the active-low heartbeat LED.
// Optional build macro SEQ_STATUS_LED_EN enables the heartbeat divider; otherwise the LED is held off.
module pool_sequencer
   import pool_sequencer_pkg::*;
#(
   parameter int POOL_SIZE      = 2,
   parameter int POOL_SIZE_LOG2 = 1,
   parameter int HASH_CYCLES    = 64,
   parameter int ROUND_W        = 6,
   parameter int LED_DIV        = 22
) (
   input  logic                      clk_in,
   input  logic                      reset_n_in,
   input  logic                      job_load_in,
   input  logic [NONCE_W-1:0]        nonce_start_in,
   input  logic                      halt_in,
   input  logic [POOL_SIZE-1:0]      core_success_in,
   output logic                      pool_clear_out,
   output logic [ROUND_W-1:0]        pool_round_out,
   output logic                      pool_strobe_out,
   output logic [NONCE_W-1:0]        nonce_base_out,
   output logic [POOL_SIZE_LOG2-1:0] winner_idx_out,
   output logic [NONCE_W-1:0]        winner_nonce_out,
   output logic                      ready_out,
   output logic                      exhausted_out,
   output logic                      busy_out,
   output logic                      status_led_n_out
);

   localparam int                 SUM_W      = NONCE_W + 1;
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(HASH_CYCLES - 1);

   seq_state_t                state, state_nxt;
   logic [ROUND_W-1:0]        round_nxt;
   logic [NONCE_W-1:0]        base_nxt;
   logic [NONCE_W-1:0]        wnonce_nxt;
   logic [POOL_SIZE_LOG2-1:0] widx_nxt;
   logic [POOL_SIZE_LOG2-1:0] hit_idx;
   logic                      hit_any;
   logic [SUM_W-1:0]          base_sum;

   pool_priority_enc #(
      .POOL_SIZE      (POOL_SIZE),
      .POOL_SIZE_LOG2 (POOL_SIZE_LOG2)
   ) u_enc (
      .req (core_success_in),
      .idx (hit_idx),
      .any (hit_any)
   );

   // Carry out of the 33-bit sum means the next stride would wrap the nonce space.
   assign base_sum = {1'b0, nonce_base_out} + SUM_W'(POOL_SIZE);

   always_comb begin
      state_nxt  = state;
      round_nxt  = pool_round_out;
      base_nxt   = nonce_base_out;
      widx_nxt   = winner_idx_out;
      wnonce_nxt = winner_nonce_out;
      if (halt_in) begin
         state_nxt = ST_IDLE;
         round_nxt = '0;
      end else if (job_load_in) begin
         state_nxt = ST_PRIME;
         round_nxt = '0;
         base_nxt  = nonce_start_in;
      end else begin
         unique case (state)
            ST_PRIME: begin
               state_nxt = ST_RUN;
               round_nxt = '0;
            end
            ST_RUN: begin
               // The registered strobe marks the last round of the attempt.
               if (pool_strobe_out) begin
                  round_nxt = '0;
                  if (hit_any) begin
                     state_nxt  = ST_FOUND;
                     widx_nxt   = hit_idx;
                     wnonce_nxt = nonce_base_out + NONCE_W'(hit_idx);
                  end else if (base_sum[NONCE_W]) begin
                     state_nxt = ST_EXHAUSTED;
                  end else begin
                     base_nxt = base_sum[NONCE_W-1:0];
                  end
               end else begin
                  round_nxt = pool_round_out + ROUND_W'(1);
               end
            end
            default: round_nxt = '0;
         endcase
      end
   end

   // Status outputs are registered decodes of the next state so they line up with it.
   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         state            <= ST_IDLE;
         pool_clear_out   <= 1'b0;
         pool_round_out   <= '0;
         pool_strobe_out  <= 1'b0;
         nonce_base_out   <= '0;
         winner_idx_out   <= '0;
         winner_nonce_out <= '0;
         ready_out        <= 1'b0;
         exhausted_out    <= 1'b0;
         busy_out         <= 1'b0;
      end else begin
         state            <= state_nxt;
         pool_clear_out   <= (state_nxt == ST_PRIME);
         pool_round_out   <= round_nxt;
         pool_strobe_out  <= (state_nxt == ST_RUN) && (round_nxt == LAST_ROUND);
         nonce_base_out   <= base_nxt;
         winner_idx_out   <= widx_nxt;
         winner_nonce_out <= wnonce_nxt;
         ready_out        <= (state_nxt == ST_FOUND);
         exhausted_out    <= (state_nxt == ST_EXHAUSTED);
         busy_out         <= (state_nxt == ST_PRIME) || (state_nxt == ST_RUN);
      end
   end

`ifdef SEQ_STATUS_LED_EN
   logic [LED_DIV-1:0] led_cnt;
   logic               led_phase, led_phase_nxt, led_n_nxt;

   // Phase flips each time the free-running divider wraps; it only reaches the pin in RUN.
   always_comb begin
      led_phase_nxt = led_phase ^ (&led_cnt);
      led_n_nxt     = 1'b1;
      case (state_nxt)
         ST_RUN:   led_n_nxt = led_phase_nxt;
         ST_FOUND: led_n_nxt = 1'b0;
         default:  led_n_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n_in) begin
         led_cnt          <= '0;
         led_phase        <= 1'b0;
         status_led_n_out <= 1'b1;
      end else begin
         led_cnt          <= led_cnt + LED_DIV'(1);
         led_phase        <= led_phase_nxt;
         status_led_n_out <= led_n_nxt;
      end
   end
`else
   // Heartbeat not built: LED held off. LED_DIV only sizes the divider of the enabled build.
   assign status_led_n_out = 1'b1 | (LED_DIV == 0);
`endif

endmodule

// File: tb/tb_pool_sequencer.sv
// Self-checking bench for pool_sequencer: directed scenarios plus randomized jobs against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pool_sequencer;

   localparam int P  = 2;
   localparam int PL = 1;
   localparam int HC = 64;
   localparam int RW = 6;
   localparam int LD = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, job_load, halt;
   logic [31:0]   nonce_start;
   logic [P-1:0]  core_success;
   logic          pool_clear, pool_strobe, ready, exhausted, busy, led_n;
   logic [RW-1:0] pool_round;
   logic [31:0]   nonce_base, winner_nonce;
   logic [PL-1:0] winner_idx;

   pool_sequencer #(
      .POOL_SIZE(P), .POOL_SIZE_LOG2(PL), .HASH_CYCLES(HC), .ROUND_W(RW), .LED_DIV(LD)
   ) dut (
      .clk_in           (clk),
      .reset_n_in       (reset_n),
      .job_load_in      (job_load),
      .nonce_start_in   (nonce_start),
      .halt_in          (halt),
      .core_success_in  (core_success),
      .pool_clear_out   (pool_clear),
      .pool_round_out   (pool_round),
      .pool_strobe_out  (pool_strobe),
      .nonce_base_out   (nonce_base),
      .winner_idx_out   (winner_idx),
      .winner_nonce_out (winner_nonce),
      .ready_out        (ready),
      .exhausted_out    (exhausted),
      .busy_out         (busy),
      .status_led_n_out (led_n)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Model: a job is described by its start nonce, the attempt that hits (-1 = never) and the
   // hit mask; everything observable follows from the number of cycles since the load.
   bit            m_valid, m_active;
   longint        m_t, m_cyc;
   logic [31:0]   m_start, m_idle_base, m_wnonce;
   int            m_hit;
   logic [P-1:0]  m_mask;
   logic [PL-1:0] m_widx;

   logic          e_clear, e_strobe, e_ready, e_exh, e_busy, e_led, e_is_strobe;
   logic [RW-1:0] e_round;
   logic [31:0]   e_base, e_wnonce;
   logic [PL-1:0] e_widx;
   logic [P-1:0]  e_sdrive;

   function automatic int lowest(input logic [P-1:0] m);
      for (int i = 0; i < P; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic void calc_expect();
      longint kexh, kf, u, k, t_end;
      bit     found;
      int     w;
      e_clear = 0; e_strobe = 0; e_ready = 0; e_exh = 0; e_busy = 0; e_round = '0;
      e_base = m_idle_base; e_widx = m_widx; e_wnonce = m_wnonce; e_led = 1;
      e_is_strobe = 0; e_sdrive = '0;
      if (!m_active) return;
      if (m_t == 1) begin
         e_clear = 1; e_busy = 1; e_base = m_start;
         return;
      end
      // Last attempt index whose stride still fits in 32 bits.
      kexh  = (64'hFFFF_FFFF - longint'(m_start)) / P;
      found = (m_hit >= 0) && (longint'(m_hit) <= kexh);
      kf    = found ? longint'(m_hit) : kexh;
      t_end = 2 + (kf + 1) * HC;
      if (m_t >= t_end) begin
         e_base = 32'(longint'(m_start) + kf * P);
         if (found) begin
            w        = lowest(m_mask);
            e_ready  = 1;
            e_widx   = PL'(w);
            e_wnonce = 32'(longint'(m_start) + kf * P + w);
         end else begin
            e_exh = 1;
         end
`ifdef SEQ_STATUS_LED_EN
         e_led = found ? 1'b0 : 1'b1;
`endif
      end else begin
         u        = m_t - 2;
         k        = u / HC;
         e_round  = RW'(u % HC);
         e_strobe = ((u % HC) == HC - 1);
         e_busy   = 1;
         e_base   = 32'(longint'(m_start) + k * P);
         e_is_strobe = e_strobe;
         e_sdrive    = (k == longint'(m_hit)) ? m_mask : '0;
`ifdef SEQ_STATUS_LED_EN
         e_led = ((m_cyc >> LD) & 1) != 0;
`endif
      end
   endfunction

   task automatic run_cycle(input bit rst, input bit hlt, input bit ld, input logic [31:0] st,
                            input int hit, input logic [P-1:0] mask);
      calc_expect();
      reset_n      = ~rst;
      halt         = hlt;
      job_load     = ld;
      nonce_start  = ld ? st : 32'($urandom);
      core_success = e_is_strobe ? e_sdrive : P'($urandom);
      @(negedge clk);
      if (m_valid) begin
         chk("clear", pool_clear, e_clear);
         chk("round", pool_round, e_round);
         chk("strobe", pool_strobe, e_strobe);
         chk("nonce_base", nonce_base, e_base);
         chk("winner_idx", winner_idx, e_widx);
         chk("winner_nonce", winner_nonce, e_wnonce);
         chk("ready", ready, e_ready);
         chk("exhausted", exhausted, e_exh);
         chk("busy", busy, e_busy);
         chk("led_n", led_n, e_led);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_valid = 1; m_active = 0; m_idle_base = '0; m_widx = '0; m_wnonce = '0; m_cyc = 0;
      end else begin
         m_cyc++;
         if (hlt || ld) begin
            m_idle_base = e_base; m_widx = e_widx; m_wnonce = e_wnonce; m_active = 0;
         end
         if (!hlt && ld) begin
            m_active = 1; m_t = 1; m_start = st; m_hit = hit; m_mask = mask;
         end else if (m_active) begin
            m_t++;
         end
      end
   endtask

   task automatic idle_cycle();
      run_cycle(0, 0, 0, 32'h0, -1, '0);
   endtask

   initial begin
      int act, dur, hit;
      logic [31:0] st;
      reset_n = 0; halt = 0; job_load = 0; nonce_start = '0; core_success = '0;
      m_valid = 0; m_active = 0; m_t = 0; m_cyc = 0; m_start = '0; m_hit = -1; m_mask = '0;
      m_idle_base = '0; m_widx = '0; m_wnonce = '0;
      @(posedge clk);
      #1;
      repeat (3) run_cycle(1, 0, 0, 32'h0, -1, '0);
      repeat (2) idle_cycle();

      // Job at 0x1000, both cores hit on the third attempt.
      run_cycle(0, 0, 1, 32'h0000_1000, 2, 2'b11);
      repeat (2 + 3 * HC + 5) idle_cycle();
      chk("hit_ready", ready, 1);
      chk("hit_widx", winner_idx, 0);
      chk("hit_wnonce", winner_nonce, 32'h0000_1004);

      // Reload while FOUND.
      run_cycle(0, 0, 1, 32'h0000_2000, -1, '0);
      chk("reload_ready", ready, 0);
      chk("reload_clear", pool_clear, 1);

      // Reset in the middle of RUN.
      repeat (20) idle_cycle();
      run_cycle(1, 0, 0, 32'h0, -1, '0);
      chk("rst_busy", busy, 0);
      chk("rst_base", nonce_base, 0);
      chk("rst_wnonce", winner_nonce, 0);
      chk("rst_led", led_n, 1);
      idle_cycle();

      // Top of nonce space, no hit.
      run_cycle(0, 0, 1, 32'hFFFF_FFFE, -1, '0);
      repeat (1 + HC + 3) idle_cycle();
      chk("exh_flag", exhausted, 1);
      chk("exh_ready", ready, 0);

      // Halt and load together.
      run_cycle(0, 1, 1, 32'h0000_3000, -1, '0);
      chk("haltload_clear", pool_clear, 0);
      chk("haltload_busy", busy, 0);
      chk("haltload_exh", exhausted, 0);
      repeat (3) idle_cycle();

      repeat (40) begin
         st  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 9))) : 32'($urandom);
         hit = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 3));
         run_cycle(0, 0, 1, st, hit, P'($urandom_range(1, 3)));
         dur = int'($urandom_range(0, 5 * HC));
         repeat (dur) idle_cycle();
         act = int'($urandom_range(0, 9));
         if (act < 3) run_cycle(0, 1, act == 0, 32'($urandom), -1, '0);
         else if (act == 3) run_cycle(1, 0, 0, 32'h0, -1, '0);
         repeat ($urandom_range(0, 3)) idle_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
